// File: rtl/ddr_rx_word_deser.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rx_word_deser
// Brief    : HDR-DDR receive deserializer: 20-bit data words to bytes, with
//            parity/preamble/length checks, CRC word detection and CRC5 compare.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_rx_word_deser #(
    parameter int           LEN_W        = 16,
    parameter bit           CHECK_PARITY = 1'b1,
    parameter logic [3:0]   CRC_TOKEN    = 4'hC
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_rx_en,
    input  logic             i_scl_edge,
    input  logic             i_sdahnd_rx_sda,
    input  logic [LEN_W-1:0] i_regf_data_len,
    input  logic [4:0]       i_crc_crc_value,
    output logic [7:0]       o_regfcrc_rx_data_out,
    output logic             o_crc_data_valid,
    output logic [LEN_W-1:0] o_rx_word_cnt,
    output logic             o_rx_busy,
    output logic             o_rx_done,
    output logic             o_rx_early_term,
    output logic             o_rx_error,
    output logic [2:0]       o_rx_error_type
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PRE     = 4'd1,
        S_DATA    = 4'd2,
        S_PAR     = 4'd3,
        S_CRC_TOK = 4'd4,
        S_CRC_VAL = 4'd5,
        S_CMP     = 4'd6,
        S_ERR     = 4'd7
    } state_t;

    localparam logic [2:0]   c_ERR_NONE    = 3'd0;
    localparam logic [2:0]   c_ERR_PARITY  = 3'd1;
    localparam logic [2:0]   c_ERR_PREAMB  = 3'd2;
    localparam logic [2:0]   c_ERR_CRC     = 3'd3;
    localparam logic [2:0]   c_ERR_OVERRUN = 3'd4;
    localparam logic [LEN_W:0] c_ONE       = {{LEN_W{1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_en_d;
    logic [LEN_W-1:0] r_len;
    logic [4:0]       r_bit_cnt;
    logic [15:0]      r_shift;
    logic             r_par_b;
    logic [4:0]       r_crc;
    logic [7:0]       r_lo_byte;
    logic             r_lo_pend;

    logic [LEN_W:0]   w_words;
    logic [LEN_W:0]   w_cnt_ext;
    logic             w_cnt_lt;
    logic             w_last_word;
    logic [1:0]       w_pre;
    logic [3:0]       w_tok;
    logic             w_p1;
    logic             w_p0;
    logic             w_par_ok;

    // Expected word count is ceil(len/2), computed one bit wider to avoid wrap.
    assign w_words     = ({1'b0, r_len} + c_ONE) >> 1;
    assign w_cnt_ext   = {1'b0, o_rx_word_cnt};
    assign w_cnt_lt    = (w_cnt_ext < w_words);
    assign w_last_word = ((w_cnt_ext + c_ONE) == w_words);
    assign w_pre       = {r_shift[0], i_sdahnd_rx_sda};
    assign w_tok       = {r_shift[2:0], i_sdahnd_rx_sda};
    assign o_rx_busy   = (r_state != S_IDLE);

    always_comb begin
        w_p1 = 1'b0;
        w_p0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_p1 = w_p1 ^ r_shift[2*i+1];
            w_p0 = w_p0 ^ r_shift[2*i];
        end
    end

    assign w_par_ok = ({r_par_b, i_sdahnd_rx_sda} == {w_p1, w_p0}) || !CHECK_PARITY;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_state               <= S_IDLE;
            r_en_d                <= 1'b0;
            r_len                 <= '0;
            r_bit_cnt             <= '0;
            r_shift               <= '0;
            r_par_b               <= 1'b0;
            r_crc                 <= '0;
            r_lo_byte             <= '0;
            r_lo_pend             <= 1'b0;
            o_regfcrc_rx_data_out <= '0;
            o_crc_data_valid      <= 1'b0;
            o_rx_word_cnt         <= '0;
            o_rx_done             <= 1'b0;
            o_rx_early_term       <= 1'b0;
            o_rx_error            <= 1'b0;
            o_rx_error_type       <= c_ERR_NONE;
        end else begin
            r_en_d           <= i_rx_en;
            o_rx_done        <= 1'b0;
            o_rx_error       <= 1'b0;
            o_crc_data_valid <= 1'b0;

            // Abort has priority over any edge sampled in the same cycle.
            if (!i_rx_en) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
                r_lo_pend <= 1'b0;
            end else begin
                if (r_lo_pend) begin
                    o_regfcrc_rx_data_out <= r_lo_byte;
                    o_crc_data_valid      <= 1'b1;
                    r_lo_pend             <= 1'b0;
                end

                case (r_state)
                    S_IDLE: begin
                        if (!r_en_d) begin
                            r_len           <= i_regf_data_len;
                            o_rx_word_cnt   <= '0;
                            o_rx_early_term <= 1'b0;
                            o_rx_error_type <= c_ERR_NONE;
                            r_bit_cnt       <= '0;
                            r_state         <= S_PRE;
                        end
                    end

                    S_PRE: begin
                        if (i_scl_edge) begin
                            r_shift <= {r_shift[14:0], i_sdahnd_rx_sda};
                            if (r_bit_cnt == 5'd0) begin
                                r_bit_cnt <= 5'd1;
                            end else begin
                                r_bit_cnt <= '0;
                                case (w_pre)
                                    2'b11: begin
                                        if (w_cnt_lt) begin
                                            r_state <= S_DATA;
                                        end else begin
                                            r_state         <= S_ERR;
                                            o_rx_error_type <= c_ERR_OVERRUN;
                                        end
                                    end
                                    2'b01: begin
                                        r_state         <= S_CRC_TOK;
                                        o_rx_early_term <= w_cnt_lt;
                                    end
                                    default: begin
                                        r_state         <= S_ERR;
                                        o_rx_error_type <= c_ERR_PREAMB;
                                    end
                                endcase
                            end
                        end
                    end

                    S_DATA: begin
                        if (i_scl_edge) begin
                            r_shift <= {r_shift[14:0], i_sdahnd_rx_sda};
                            if (r_bit_cnt == 5'd15) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_PAR;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    // r_shift is frozen here so the word survives until emitted.
                    S_PAR: begin
                        if (i_scl_edge) begin
                            if (r_bit_cnt == 5'd0) begin
                                r_par_b   <= i_sdahnd_rx_sda;
                                r_bit_cnt <= 5'd1;
                            end else begin
                                r_bit_cnt <= '0;
                                if (w_par_ok) begin
                                    o_regfcrc_rx_data_out <= r_shift[15:8];
                                    o_crc_data_valid      <= 1'b1;
                                    o_rx_word_cnt         <= o_rx_word_cnt + 1'b1;
                                    r_lo_byte             <= r_shift[7:0];
                                    r_lo_pend             <= !(w_last_word && r_len[0]);
                                    r_state               <= S_PRE;
                                end else begin
                                    r_state         <= S_ERR;
                                    o_rx_error_type <= c_ERR_PARITY;
                                end
                            end
                        end
                    end

                    S_CRC_TOK: begin
                        if (i_scl_edge) begin
                            r_shift <= {r_shift[14:0], i_sdahnd_rx_sda};
                            if (r_bit_cnt == 5'd3) begin
                                r_bit_cnt <= '0;
                                if (w_tok == CRC_TOKEN) begin
                                    r_state <= S_CRC_VAL;
                                end else begin
                                    r_state         <= S_ERR;
                                    o_rx_error_type <= c_ERR_PREAMB;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    S_CRC_VAL: begin
                        if (i_scl_edge) begin
                            r_crc <= {r_crc[3:0], i_sdahnd_rx_sda};
                            if (r_bit_cnt == 5'd4) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_CMP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    // One cycle of slack lets the CRC engine absorb the last byte.
                    S_CMP: begin
                        o_rx_done <= 1'b1;
                        if (r_crc != i_crc_crc_value) begin
                            o_rx_error      <= 1'b1;
                            o_rx_error_type <= c_ERR_CRC;
                        end
                        r_state <= S_IDLE;
                    end

                    S_ERR: begin
                        o_rx_done  <= 1'b1;
                        o_rx_error <= 1'b1;
                        r_state    <= S_IDLE;
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_rx_word_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_rx_word_deser
// Brief    : Directed self-checking bench for ddr_rx_word_deser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_rx_word_deser;

    logic        clk;
    logic        rst_n;
    logic        rx_en;
    logic        scl_edge;
    logic        sda;
    logic [15:0] len;
    logic [4:0]  crc_val;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [15:0] word_cnt;
    logic        busy;
    logic        done;
    logic        early;
    logic        err;
    logic [2:0]  err_type;

    int n_cmp;
    int n_bad;
    int cyc;
    int done_cnt;
    int err_cnt;
    logic [7:0] got[$];
    int         got_cyc[$];

    ddr_rx_word_deser #(
        .LEN_W        (16),
        .CHECK_PARITY (1'b1),
        .CRC_TOKEN    (4'hC)
    ) dut (
        .i_sys_clk             (clk),
        .i_sys_rst             (rst_n),
        .i_rx_en               (rx_en),
        .i_scl_edge            (scl_edge),
        .i_sdahnd_rx_sda       (sda),
        .i_regf_data_len       (len),
        .i_crc_crc_value       (crc_val),
        .o_regfcrc_rx_data_out (data_out),
        .o_crc_data_valid      (data_valid),
        .o_rx_word_cnt         (word_cnt),
        .o_rx_busy             (busy),
        .o_rx_done             (done),
        .o_rx_early_term       (early),
        .o_rx_error            (err),
        .o_rx_error_type       (err_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (data_valid) begin
            got.push_back(data_out);
            got_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            if (err) err_cnt++;
        end
    end

    function automatic logic [39:0] bytes_seen();
        logic [31:0] r;
        r = '0;
        foreach (got[i]) r = {r[23:0], got[i]};
        return {8'(got.size()), r};
    endfunction

    task automatic send_bit(input logic b);
        sda      = b;
        scl_edge = 1'b1;
        @(posedge clk); #1;
        scl_edge = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [19:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [1:0] pre, input logic [15:0] d, input logic [1:0] p);
        send_bits({pre, d, p}, 20);
    endtask

    task automatic send_crc(input logic [3:0] tok, input logic [4:0] c);
        send_bits({9'd0, 2'b01, tok, c}, 11);
    endtask

    task automatic start(input logic [15:0] l);
        rx_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got.delete();
        got_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        len      = l;
        rx_en    = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        n_cmp++; if (word_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", word_cnt); end
        n_cmp++; if ({busy, done, early, err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, early, err}); end
        n_cmp++; if (err_type !== 3'd0) begin n_bad++; $display("FAIL reset_type: got %0d expected 0", err_type); end
    endtask

    task automatic test_single_word();
        start(16'd2);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", busy); end
        send_word(2'b11, 16'hA55A, 2'b01);
        send_crc(4'hC, 5'h04);
        settle();
        n_cmp++; if (bytes_seen() !== {8'd2, 32'h0000A55A}) begin n_bad++; $display("FAIL single_bytes: got %h expected 020000a55a", bytes_seen()); end
        n_cmp++; if (got.size() != 2 || (got_cyc[1] - got_cyc[0]) != 1) begin n_bad++; $display("FAIL single_consec: got %0d strobes expected 2 in consecutive cycles", got.size()); end
        n_cmp++; if (word_cnt !== 16'd1) begin n_bad++; $display("FAIL single_cnt: got %0d expected 1", word_cnt); end
        n_cmp++; if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL single_done: got done=%0d err=%0d expected 1/0", done_cnt, err_cnt); end
        n_cmp++; if ({busy, early, err_type} !== 5'b0_0_000) begin n_bad++; $display("FAIL single_final: got busy=%b early=%b type=%0d expected 0/0/0", busy, early, err_type); end
    endtask

    task automatic test_parity();
        start(16'd2);
        send_word(2'b11, 16'hA55A, 2'b10);
        settle();
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL parity_bytes: got %0d strobes expected 0", got.size()); end
        n_cmp++; if ({done_cnt, err_cnt} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL parity_pulse: got done=%0d err=%0d expected 1/1", done_cnt, err_cnt); end
        n_cmp++; if (err_type !== 3'd1) begin n_bad++; $display("FAIL parity_type: got %0d expected 1", err_type); end
        n_cmp++; if (word_cnt !== 16'd0) begin n_bad++; $display("FAIL parity_cnt: got %0d expected 0", word_cnt); end
    endtask

    task automatic test_odd_len();
        start(16'd3);
        send_word(2'b11, 16'h1234, 2'b00);
        send_word(2'b11, 16'h5600, 2'b10);
        send_crc(4'hC, 5'h04);
        settle();
        n_cmp++; if (bytes_seen() !== {8'd3, 32'h00123456}) begin n_bad++; $display("FAIL odd_bytes: got %h expected 0300123456", bytes_seen()); end
        n_cmp++; if (word_cnt !== 16'd2) begin n_bad++; $display("FAIL odd_cnt: got %0d expected 2", word_cnt); end
        n_cmp++; if ({done_cnt, err_cnt, 29'd0, err_type} !== {32'd1, 32'd0, 32'd0}) begin n_bad++; $display("FAIL odd_done: got done=%0d err=%0d type=%0d expected 1/0/0", done_cnt, err_cnt, err_type); end
    endtask

    task automatic test_early_term();
        start(16'd4);
        send_word(2'b11, 16'hA55A, 2'b01);
        send_crc(4'hC, 5'h04);
        settle();
        n_cmp++; if (early !== 1'b1) begin n_bad++; $display("FAIL early_flag: got %b expected 1", early); end
        n_cmp++; if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL early_done: got done=%0d err=%0d expected 1/0", done_cnt, err_cnt); end
        n_cmp++; if (word_cnt !== 16'd1) begin n_bad++; $display("FAIL early_cnt: got %0d expected 1", word_cnt); end
    endtask

    task automatic test_len_zero();
        start(16'd0);
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL zero_clear: got early=%b expected 0", early); end
        send_crc(4'hC, 5'h04);
        settle();
        n_cmp++; if ({done_cnt, err_cnt, 29'd0, err_type} !== {32'd1, 32'd0, 32'd0}) begin n_bad++; $display("FAIL zero_done: got done=%0d err=%0d type=%0d expected 1/0/0", done_cnt, err_cnt, err_type); end
        n_cmp++; if ({early, word_cnt} !== 17'd0) begin n_bad++; $display("FAIL zero_state: got early=%b cnt=%0d expected 0/0", early, word_cnt); end
    endtask

    task automatic test_overrun();
        start(16'd2);
        send_word(2'b11, 16'hA55A, 2'b01);
        send_bits(20'b11, 2);
        settle();
        n_cmp++; if (err_type !== 3'd4) begin n_bad++; $display("FAIL overrun_type: got %0d expected 4", err_type); end
        n_cmp++; if ({done_cnt, err_cnt} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL overrun_pulse: got done=%0d err=%0d expected 1/1", done_cnt, err_cnt); end
        n_cmp++; if (bytes_seen() !== {8'd2, 32'h0000A55A}) begin n_bad++; $display("FAIL overrun_bytes: got %h expected 020000a55a", bytes_seen()); end
    endtask

    task automatic test_abort();
        start(16'd2);
        send_bits(20'b11_10110, 7);
        rx_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if ({done_cnt, err_cnt} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL abort_pulse: got done=%0d err=%0d expected 0/0", done_cnt, err_cnt); end
        start(16'd2);
        send_word(2'b11, 16'hA55A, 2'b01);
        send_crc(4'hC, 5'h04);
        settle();
        n_cmp++; if ({done_cnt, err_cnt, 29'd0, err_type} !== {32'd1, 32'd0, 32'd0}) begin n_bad++; $display("FAIL abort_restart: got done=%0d err=%0d type=%0d expected 1/0/0", done_cnt, err_cnt, err_type); end
        n_cmp++; if (bytes_seen() !== {8'd2, 32'h0000A55A}) begin n_bad++; $display("FAIL abort_bytes: got %h expected 020000a55a", bytes_seen()); end
    endtask

    task automatic test_crc_mismatch();
        crc_val = 5'h05;
        start(16'd2);
        send_word(2'b11, 16'hA55A, 2'b01);
        send_crc(4'hC, 5'h04);
        settle();
        n_cmp++; if (err_type !== 3'd3) begin n_bad++; $display("FAIL crc_type: got %0d expected 3", err_type); end
        n_cmp++; if ({done_cnt, err_cnt} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL crc_pulse: got done=%0d err=%0d expected 1/1", done_cnt, err_cnt); end
        crc_val = 5'h04;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        done_cnt = 0;
        err_cnt  = 0;
        rst_n    = 1'b0;
        rx_en    = 1'b0;
        scl_edge = 1'b0;
        sda      = 1'b0;
        len      = 16'd0;
        crc_val  = 5'h04;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single_word();
        test_parity();
        test_odd_len();
        test_early_term();
        test_len_zero();
        test_overrun();
        test_abort();
        test_crc_mismatch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
